// File: rtl/cpu_cond_pkg.sv
// Shared condition-code definitions for the flag/condition logic and the branch unit.
package cpu_cond_pkg;

    typedef logic [3:0] nzcv_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition decode; shared with the branch unit.
module cond_eval
    import cpu_cond_pkg::*;
(
    input  nzcv_t      nzcv,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flags_unit.sv
// Status register plus one-deep condition-evaluation stage with valid/ready output.
// Define FLAG_SHADOW_EN to add an interrupt shadow copy of the flags and irq_enter/irq_exit.
module cond_flags_unit
    import cpu_cond_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  nzcv_t       flags_in,
    input  logic        flags_we,
    input  logic        cond_valid,
    input  logic [3:0]  cond,
    output logic        cond_ready,
    output logic        exec_valid,
    output logic        exec_en,
    input  logic        exec_ready,
    output nzcv_t       flags_q,
    output logic [15:0] skip_cnt
`ifdef FLAG_SHADOW_EN
    ,
    input  logic        irq_enter,
    input  logic        irq_exit
`endif
);

    nzcv_t       flags_d;
    nzcv_t       next_flags;
    logic        pass;
    logic        accept;
    logic        exec_valid_d, exec_valid_q;
    logic        exec_en_d, exec_en_q;
    logic [15:0] skip_cnt_d, skip_cnt_q;
`ifdef FLAG_SHADOW_EN
    nzcv_t       shadow_d, shadow_q;
`endif

    // Evaluate against the flags being written this cycle so a compare
    // immediately followed by a conditional instruction costs no bubble.
    cond_eval u_cond_eval (
        .nzcv (next_flags),
        .cond (cond),
        .pass (pass)
    );

    always_comb begin
        next_flags = flags_we ? flags_in : flags_q;
`ifdef FLAG_SHADOW_EN
        shadow_d = shadow_q;
        if (irq_enter) shadow_d = next_flags;
        if (irq_exit)  next_flags = shadow_q;
`endif
        flags_d = next_flags;

        cond_ready   = !exec_valid_q | exec_ready;
        accept       = cond_valid & cond_ready;
        exec_valid_d = exec_valid_q;
        exec_en_d    = exec_en_q;
        skip_cnt_d   = skip_cnt_q;
        if (accept) begin
            exec_valid_d = 1'b1;
            exec_en_d    = pass;
            if (!pass && skip_cnt_q != 16'hFFFF) skip_cnt_d = skip_cnt_q + 16'd1;
        end else if (exec_ready) begin
            exec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q      <= 4'b0000;
            exec_valid_q <= 1'b0;
            exec_en_q    <= 1'b0;
            skip_cnt_q   <= 16'd0;
`ifdef FLAG_SHADOW_EN
            shadow_q     <= 4'b0000;
`endif
        end else begin
            flags_q      <= flags_d;
            exec_valid_q <= exec_valid_d;
            exec_en_q    <= exec_en_d;
            skip_cnt_q   <= skip_cnt_d;
`ifdef FLAG_SHADOW_EN
            shadow_q     <= shadow_d;
`endif
        end
    end

    assign exec_valid = exec_valid_q;
    assign exec_en    = exec_en_q;
    assign skip_cnt   = skip_cnt_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Scoreboard bench: stimulus queues expected exec_en per acceptance, monitor pops on consumption.
module tb_cond_flags_unit;
    import cpu_cond_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    nzcv_t       flags_in = 4'b0000;
    logic        flags_we = 1'b0;
    logic        cond_valid = 1'b0;
    logic [3:0]  cond = 4'h0;
    logic        cond_ready;
    logic        exec_valid;
    logic        exec_en;
    logic        exec_ready = 1'b1;
    nzcv_t       flags_q;
    logic [15:0] skip_cnt;
`ifdef FLAG_SHADOW_EN
    logic        irq_enter = 1'b0;
    logic        irq_exit = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    int   stall_cycles = 0;
    logic exp_q[$];

    cond_flags_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flags_in   (flags_in),
        .flags_we   (flags_we),
        .cond_valid (cond_valid),
        .cond       (cond),
        .cond_ready (cond_ready),
        .exec_valid (exec_valid),
        .exec_en    (exec_en),
        .exec_ready (exec_ready),
        .flags_q    (flags_q),
        .skip_cnt   (skip_cnt)
`ifdef FLAG_SHADOW_EN
        ,
        .irq_enter  (irq_enter),
        .irq_exit   (irq_exit)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cond_valid = 1'b0;
        flags_we   = 1'b0;
    endtask

    task automatic drain();
        idle();
        exec_ready = 1'b1;
        step();
        step();
    endtask

    task automatic set_flags(input nzcv_t f);
        flags_we = 1'b1;
        flags_in = f;
        step();
        flags_we = 1'b0;
    endtask

    // Present one condition; queue its expected result once the unit accepts it.
    task automatic issue(input logic [3:0] c, input logic exp, input logic fw, input nzcv_t fin);
        cond_valid = 1'b1;
        cond       = c;
        flags_we   = fw;
        flags_in   = fin;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cond_ready) begin
                exp_q.push_back(exp);
                step();
                flags_we = 1'b0;
                return;
            end
            stall_cycles++;
            step();
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: cond %h never accepted", c);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && exec_valid && exec_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got exec_en %b with no result queued", exec_en);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    if (exec_en !== e) begin
                        errors++;
                        $display("FAIL sb_exec_en: got %b expected %b", exec_en, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int sc;
        #1;
        chk("rst_flags", 16'(flags_q), 16'h0);
        chk("rst_exec_valid", 16'(exec_valid), 16'h0);
        chk("rst_exec_en", 16'(exec_en), 16'h0);
        chk("rst_skip", skip_cnt, 16'h0);
        chk("rst_cond_ready", 16'(cond_ready), 16'h1);
        step();
        step();
        rst_n = 1'b1;

        // EQ with Z clear squashes
        issue(COND_EQ, 1'b0, 1'b0, 4'b0000);
        idle();
        chk("eq_valid", 16'(exec_valid), 16'h1);
        chk("eq_en", 16'(exec_en), 16'h0);
        chk("eq_skip", skip_cnt, 16'd1);

        // same-cycle flag write is forwarded
        issue(COND_EQ, 1'b1, 1'b1, 4'b0100);
        idle();
        chk("fwd_en", 16'(exec_en), 16'h1);
        chk("fwd_flags", 16'(flags_q), 16'h4);
        chk("fwd_skip", skip_cnt, 16'd1);
        drain();

        // back-to-back with N=1 V=1
        sc = stall_cycles;
        issue(COND_GE, 1'b1, 1'b1, 4'b1001);
        issue(COND_LT, 1'b0, 1'b0, 4'b0000);
        issue(COND_GT, 1'b1, 1'b0, 4'b0000);
        issue(COND_LE, 1'b0, 1'b0, 4'b0000);
        issue(COND_HI, 1'b0, 1'b0, 4'b0000);
        issue(COND_AL, 1'b1, 1'b0, 4'b0000);
        issue(COND_NV, 1'b0, 1'b0, 4'b0000);
        idle();
        chk("b2b_stalls", 16'(stall_cycles - sc), 16'd0);
        chk("b2b_flags", 16'(flags_q), 16'h9);
        chk("b2b_skip", skip_cnt, 16'd5);
        drain();

        // backpressure: result must hold while exec_ready is low
        exec_ready = 1'b0;
        issue(COND_AL, 1'b1, 1'b0, 4'b0000);
        cond = COND_EQ;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_cond_ready", 16'(cond_ready), 16'h0);
            chk("stall_valid", 16'(exec_valid), 16'h1);
            chk("stall_en", 16'(exec_en), 16'h1);
            step();
        end
        exec_ready = 1'b1;
        @(negedge clk);
        chk("release_cond_ready", 16'(cond_ready), 16'h1);
        if (cond_ready) exp_q.push_back(1'b0);
        step();
        idle();
        chk("release_valid", 16'(exec_valid), 16'h1);
        chk("release_en", 16'(exec_en), 16'h0);
        chk("release_skip", skip_cnt, 16'd6);
        drain();

`ifdef FLAG_SHADOW_EN
        set_flags(4'b0010);
        irq_enter = 1'b1;
        step();
        irq_enter = 1'b0;
        set_flags(4'b1000);
        chk("shadow_pre_exit", 16'(flags_q), 16'h8);
        irq_exit = 1'b1;
        step();
        irq_exit = 1'b0;
        chk("shadow_restore", 16'(flags_q), 16'h2);
        irq_enter = 1'b1;
        set_flags(4'b1000);
        irq_enter = 1'b0;
        set_flags(4'b0001);
        irq_enter = 1'b1;
        irq_exit  = 1'b1;
        step();
        irq_enter = 1'b0;
        irq_exit  = 1'b0;
        chk("shadow_swap_flags", 16'(flags_q), 16'h8);
        irq_exit = 1'b1;
        step();
        irq_exit = 1'b0;
        chk("shadow_swap_saved", 16'(flags_q), 16'h1);
`endif

        // saturate skip counter (currently 6)
        for (int i = 0; i < 65528; i++) issue(COND_NV, 1'b0, 1'b0, 4'b0000);
        chk("sat_fffe", skip_cnt, 16'hFFFE);
        issue(COND_NV, 1'b0, 1'b0, 4'b0000);
        chk("sat_ffff", skip_cnt, 16'hFFFF);
        issue(COND_NV, 1'b0, 1'b0, 4'b0000);
        chk("sat_hold", skip_cnt, 16'hFFFF);
        drain();

        // asynchronous reset discards a stalled result
        exec_ready = 1'b0;
        cond_valid = 1'b1;
        cond       = COND_AL;
        step();
        idle();
        chk("pend_valid", 16'(exec_valid), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 16'(exec_valid), 16'h0);
        chk("async_en", 16'(exec_en), 16'h0);
        chk("async_skip", skip_cnt, 16'h0);
        chk("async_flags", 16'(flags_q), 16'h0);
        step();
        rst_n = 1'b0;
        exec_ready = 1'b1;
        step();
        rst_n = 1'b1;

        sc = stall_cycles;
        issue(COND_EQ, 1'b0, 1'b0, 4'b0000);
        idle();
        chk("first_accept_stalls", 16'(stall_cycles - sc), 16'd0);
        chk("first_accept_skip", skip_cnt, 16'd1);
        drain();
        chk("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_flags_unit.md
COND_FLAGS_UNIT -- requirements
Module: cond_flags_unit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flags_in  input  4  {N,Z,C,V} from the flag generator.
REQ-005 flags_we  input  1  writes flags_in into the status register this cycle.
REQ-006 cond_valid  input  1  an instruction's condition field is presented.
REQ-007 cond  input  4  condition code of the presented instruction.
REQ-008 cond_ready  output  1  the unit accepts cond this cycle.
REQ-009 exec_valid  output  1  the registered result is valid.
REQ-010 exec_en  output  1  1 = condition passed, execute; 0 = squash.
REQ-011 exec_ready  input  1  the downstream stage consumes the result.
REQ-012 flags_q  output  4  architectural status register {N,Z,C,V}.
REQ-013 skip_cnt  output  16  count of squashed instructions, saturating.
REQ-014 irq_enter, irq_exit  input  1 each  present only with FLAG_SHADOW_EN.

Function
REQ-015 Flag update rule: next_flags = flags_in when flags_we=1, otherwise flags_q.
- Registered at the next edge.
REQ-016 Condition evaluation uses next_flags, so a flags write in the same cycle is forwarded with 0-cycle penalty.
REQ-017 Condition map:
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
- 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
- E AL 1; F NV 0
REQ-018 cond_ready = !exec_valid | exec_ready, combinational, with no dependence on cond_valid.
REQ-019 Acceptance (cond_valid & cond_ready):
- exec_valid<=1 and exec_en<=evaluated result at the next edge.
- Latency is 1 cycle.
REQ-020 When exec_valid=1 and exec_ready=0, exec_valid and exec_en SHALL hold stable.
REQ-021 When the result is consumed and no new acceptance occurs, exec_valid<=0.
REQ-022 Back-to-back acceptance at full throughput SHALL be supported when exec_ready=1.
REQ-023 skip_cnt SHALL increment by 1 on each acceptance whose result is 0, and saturate at 16'hFFFF.
REQ-024 flags_we SHALL take effect regardless of cond_valid, cond_ready or exec_ready.
REQ-025 All outputs SHALL be driven directly from registers, except cond_ready.

Reset
REQ-026 On rst_n=0, immediately: flags_q=4'b0000, exec_valid=0, exec_en=0, skip_cnt=0, shadow=4'b0000.
REQ-027 A pending unconsumed result SHALL be discarded by reset.
REQ-028 The first acceptance is possible on the first rising edge after rst_n rises.

Configuration
REQ-029 With macro FLAG_SHADOW_EN defined, the block SHALL have a 4-bit shadow register and the irq_enter/irq_exit ports.
- irq_exit=1: next_flags=shadow, overriding flags_we.
- irq_enter=1: shadow<=(flags_we ? flags_in : flags_q).
- Both asserted together: flags and shadow swap, with flags_we applied to the value saved.
- Condition evaluation in that cycle uses the restored next_flags.
REQ-030 Without FLAG_SHADOW_EN, there SHALL be no shadow register and no irq ports, and REQ-015 applies unchanged.

Structure
REQ-031 Shared package cpu_cond_pkg SHALL hold:
- condition-code constants COND_EQ..COND_NV;
- flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
- a nzcv_t 4-bit typedef.
REQ-032 Combinational condition decode SHALL be the sub-module cond_eval (inputs nzcv, cond; output pass), which is reusable by the branch unit.

Verification
REQ-033 Reset, then cond_valid=1, cond=EQ, flags_we=0, exec_ready=1 -> next cycle exec_valid=1, exec_en=0, skip_cnt=1.
REQ-034 Same cycle flags_we=1, flags_in=4'b0100, cond_valid=1, cond=EQ -> next cycle exec_en=1, flags_q=4'b0100.
REQ-035 flags_q=4'b1001, conditions GE, LT, GT, LE, HI, AL, NV issued back-to-back with exec_ready=1 -> exec_en sequence 1,0,1,0,0,1,0, one per cycle.
REQ-036 exec_ready=0 for 3 cycles after acceptance -> cond_ready=0, exec_valid/exec_en stable.
- exec_ready then 1 -> the result is consumed and the next instruction is accepted in the same cycle.
REQ-037 skip_cnt preloaded by 65535 NV acceptances, then one more NV -> skip_cnt stays 16'hFFFF.
- rst_n pulsed low mid-stall -> exec_valid=0 and skip_cnt=0 without a clock edge.
REQ-038 FLAG_SHADOW_EN defined:
- flags_q=4'b0010, then irq_enter -> shadow=4'b0010.
- Then flags_we with 4'b1000, then irq_exit -> flags_q=4'b0010.
- irq_enter and irq_exit together -> flags_q and shadow swap.
